jedro_1_wb_arbiter: RTL and testbench
=====================================

JEDRO_1_WB_ARBITER -- requirements
Module: jedro_1_wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register data width.
REQ-002 Parameter ADDR_WIDTH, default 5, register address width; NUM_REGS = 2**ADDR_WIDTH.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rstn_i  input  1  reset; asynchronous, active-low.
REQ-005 alu_valid_i  input  1  ALU writeback request.
REQ-006 alu_addr_i  input  ADDR_WIDTH  ALU destination register.
REQ-007 alu_data_i  input  DATA_WIDTH  ALU result.
REQ-008 alu_ready_o  output  1  ALU request accepted this cycle.
REQ-009 lsu_valid_i  input  1  LSU writeback request.
REQ-010 lsu_addr_i  input  ADDR_WIDTH  LSU destination register.
REQ-011 lsu_data_i  input  DATA_WIDTH  load data.
REQ-012 lsu_ready_o  output  1  LSU request accepted this cycle.
REQ-013 wpc_addr_o  output  ADDR_WIDTH  register-file write port C address, registered.
REQ-014 wpc_data_o  output  DATA_WIDTH  write port C data, registered.
REQ-015 wpc_we_o  output  1  write port C enable, registered.
REQ-016 init_done_o  output  1  register-file clear sequence complete, registered.

Function
REQ-017 The FSM SHALL have two states, INIT and RUN; reset state is INIT.
REQ-018 In INIT, a counter (reset value 1) SHALL supply addresses; each edge loads wpc_we_o=1, wpc_addr_o=counter, wpc_data_o=0, then increments the counter.
REQ-019 On the edge that loads address NUM_REGS-1, the FSM SHALL enter RUN and set init_done_o=1; INIT thus issues exactly NUM_REGS-1 writes (31 at default) and never writes x0.
REQ-020 In INIT, alu_ready_o and lsu_ready_o SHALL both be 0 regardless of the valid inputs.
REQ-021 In RUN, the grant SHALL be combinational: one valid requester is granted; with both valid, the requester not granted most recently is granted.
REQ-022 The last-grant pointer SHALL reset to ALU, so the LSU wins the first contended cycle.
REQ-023 In RUN, x_ready_o SHALL equal 1 only for the granted requester, and it SHALL be 0 when that requester's valid is 0.
REQ-024 A transfer occurs when x_valid_i and x_ready_o are both 1; at most one transfer per cycle.
REQ-025 On a transfer edge, outputs SHALL load wpc_addr_o=x_addr_i, wpc_data_o=x_data_i, and wpc_we_o=(x_addr_i!=0); the pointer SHALL update to the granted requester.
REQ-026 A write to x0 SHALL be accepted (ready=1) and consumed with wpc_we_o=0.
REQ-027 In RUN with no transfer, wpc_we_o SHALL be 0 on the next cycle, and wpc_addr_o and wpc_data_o SHALL hold their values.
REQ-028 Latency from transfer edge to wpc_we_o=1 SHALL be one cycle; sustained throughput SHALL be one write per cycle.
REQ-029 A requester not granted SHALL be allowed to hold its valid, address, and data, and SHALL be granted no later than the next cycle in which the other requester is granted.
REQ-030 Successive writes to the same address SHALL reach port C in grant order; the arbiter SHALL perform no merging or reordering.
REQ-031 RUN SHALL persist until reset; there SHALL be no return to INIT otherwise.

Reset
REQ-032 While rstn_i=0, the block SHALL hold: state=INIT, counter=1, pointer=ALU, wpc_we_o=0, wpc_addr_o=0, wpc_data_o=0, init_done_o=0, alu_ready_o=0, lsu_ready_o=0.
REQ-033 Assertion of rstn_i at any point, mid-INIT or mid-RUN, SHALL clear all state immediately and restart INIT from address 1 after release; in-flight requests are dropped.

Verification
REQ-034 Release reset with both valids high: port C writes 0 to addresses 1..31 on consecutive cycles, readies stay 0, init_done_o rises with the address-31 write, and no other write occurs.
REQ-035 In RUN, ALU-only valid with addr=5 and data=0xDEADBEEF for one cycle: alu_ready_o=1, and the next cycle shows wpc_we_o=1, addr=5, data=0xDEADBEEF, followed by wpc_we_o=0.
REQ-036 In RUN, both valid continuously (ALU addr=3 data=0xA, LSU addr=4 data=0xB): grants alternate LSU, ALU, LSU, ..., and port C alternates 4/0xB and 3/0xA every cycle with no idle cycle.
REQ-037 In RUN, LSU write to addr=0 with data=0x1234: lsu_ready_o=1, then wpc_we_o=0 on the following cycle.
REQ-038 Assert rstn_i=0 at INIT address 12, then release: outputs clear asynchronously, and INIT restarts at address 1 and completes after 31 writes.

Source files
------------

// File: rtl/jedro_1_wb_arbiter_if.sv
// Register-file write-back bus between the ALU/LSU requesters and the
// write-back arbiter, including the arbiter's write port C and the
// init-complete flag.
interface jedro_1_wb_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);

   // ALU write-back request channel
   logic                  alu_valid_i;
   logic [ADDR_WIDTH-1:0] alu_addr_i;
   logic [DATA_WIDTH-1:0] alu_data_i;
   logic                  alu_ready_o;

   // LSU write-back request channel
   logic                  lsu_valid_i;
   logic [ADDR_WIDTH-1:0] lsu_addr_i;
   logic [DATA_WIDTH-1:0] lsu_data_i;
   logic                  lsu_ready_o;

   // Register-file write port C and init status
   logic [ADDR_WIDTH-1:0] wpc_addr_o;
   logic [DATA_WIDTH-1:0] wpc_data_o;
   logic                  wpc_we_o;
   logic                  init_done_o;

   // Arbiter side of the bus
   modport slave (
      input  alu_valid_i,
      input  alu_addr_i,
      input  alu_data_i,
      output alu_ready_o,
      input  lsu_valid_i,
      input  lsu_addr_i,
      input  lsu_data_i,
      output lsu_ready_o,
      output wpc_addr_o,
      output wpc_data_o,
      output wpc_we_o,
      output init_done_o
   );

   // Requester / register-file side of the bus
   modport master (
      output alu_valid_i,
      output alu_addr_i,
      output alu_data_i,
      input  alu_ready_o,
      output lsu_valid_i,
      output lsu_addr_i,
      output lsu_data_i,
      input  lsu_ready_o,
      input  wpc_addr_o,
      input  wpc_data_o,
      input  wpc_we_o,
      input  init_done_o
   );

endinterface : jedro_1_wb_arbiter_if

// File: rtl/jedro_1_wb_arbiter.sv
// Write-back arbiter for the jedro_1 register file.
// After reset it walks addresses 1..NUM_REGS-1 writing zero through port C
// (x0 is hard-wired and never written). It then arbitrates ALU and LSU
// write-back requests onto port C, one write per cycle, alternating grants
// when both request so neither can starve.
module jedro_1_wb_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input logic                 clk_i,
   input logic                 rstn_i,
   jedro_1_wb_arbiter_if.slave bus
);

   localparam int                    NUM_REGS  = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(NUM_REGS - 1);
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   logic [ADDR_WIDTH-1:0] cnt_r;
   logic [ADDR_WIDTH-1:0] cnt_nxt_s;
   // 1'b0 = ALU granted most recently, 1'b1 = LSU granted most recently
   logic                  last_lsu_r;
   logic                  last_lsu_nxt_s;

   logic [ADDR_WIDTH-1:0] wpc_addr_r;
   logic [ADDR_WIDTH-1:0] wpc_addr_nxt_s;
   logic [DATA_WIDTH-1:0] wpc_data_r;
   logic [DATA_WIDTH-1:0] wpc_data_nxt_s;
   logic                  wpc_we_r;
   logic                  wpc_we_nxt_s;
   logic                  init_done_r;
   logic                  init_done_nxt_s;

   logic                  grant_alu_s;
   logic                  grant_lsu_s;

   // Combinational grant: only in RUN, only to a valid requester, and on
   // contention to whichever side did not win last time.
   always_comb begin
      grant_alu_s = 1'b0;
      grant_lsu_s = 1'b0;
      if (state_r == ST_RUN) begin
         if (bus.alu_valid_i && bus.lsu_valid_i) begin
            if (last_lsu_r) begin
               grant_alu_s = 1'b1;
            end else begin
               grant_lsu_s = 1'b1;
            end
         end else begin
            grant_alu_s = bus.alu_valid_i;
            grant_lsu_s = bus.lsu_valid_i;
         end
      end else begin
         grant_alu_s = 1'b0;
         grant_lsu_s = 1'b0;
      end
   end

   // A grant implies the requester is valid, so a grant is a transfer.
   assign bus.alu_ready_o = grant_alu_s;
   assign bus.lsu_ready_o = grant_lsu_s;

   // Next-state and next-output logic for the INIT sweep and RUN arbitration.
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      last_lsu_nxt_s  = last_lsu_r;
      wpc_addr_nxt_s  = wpc_addr_r;
      wpc_data_nxt_s  = wpc_data_r;
      wpc_we_nxt_s    = 1'b0;
      init_done_nxt_s = init_done_r;

      case (state_r)
         ST_INIT: begin
            // Clear one register per cycle, x1 upwards.
            wpc_we_nxt_s   = 1'b1;
            wpc_addr_nxt_s = cnt_r;
            wpc_data_nxt_s = DATA_ZERO;
            cnt_nxt_s      = cnt_r + ADDR_ONE;
            if (cnt_r == ADDR_LAST) begin
               state_nxt_s     = ST_RUN;
               init_done_nxt_s = 1'b1;
            end else begin
               state_nxt_s     = ST_INIT;
               init_done_nxt_s = 1'b0;
            end
         end

         ST_RUN: begin
            state_nxt_s = ST_RUN;
            if (grant_alu_s) begin
               wpc_addr_nxt_s = bus.alu_addr_i;
               wpc_data_nxt_s = bus.alu_data_i;
               // Writes to x0 are accepted but never reach the register file.
               wpc_we_nxt_s   = (bus.alu_addr_i != ADDR_ZERO);
               last_lsu_nxt_s = 1'b0;
            end else if (grant_lsu_s) begin
               wpc_addr_nxt_s = bus.lsu_addr_i;
               wpc_data_nxt_s = bus.lsu_data_i;
               wpc_we_nxt_s   = (bus.lsu_addr_i != ADDR_ZERO);
               last_lsu_nxt_s = 1'b1;
            end else begin
               // Idle cycle: address and data hold, enable drops.
               wpc_we_nxt_s = 1'b0;
            end
         end

         default: begin
            state_nxt_s     = ST_INIT;
            cnt_nxt_s       = ADDR_ONE;
            last_lsu_nxt_s  = 1'b0;
            wpc_addr_nxt_s  = ADDR_ZERO;
            wpc_data_nxt_s  = DATA_ZERO;
            wpc_we_nxt_s    = 1'b0;
            init_done_nxt_s = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_r <= ST_INIT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Init counter, grant pointer and registered port C / status outputs.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_r       <= ADDR_ONE;
         last_lsu_r  <= 1'b0;
         wpc_addr_r  <= ADDR_ZERO;
         wpc_data_r  <= DATA_ZERO;
         wpc_we_r    <= 1'b0;
         init_done_r <= 1'b0;
      end else begin
         cnt_r       <= cnt_nxt_s;
         last_lsu_r  <= last_lsu_nxt_s;
         wpc_addr_r  <= wpc_addr_nxt_s;
         wpc_data_r  <= wpc_data_nxt_s;
         wpc_we_r    <= wpc_we_nxt_s;
         init_done_r <= init_done_nxt_s;
      end
   end

   assign bus.wpc_addr_o  = wpc_addr_r;
   assign bus.wpc_data_o  = wpc_data_r;
   assign bus.wpc_we_o    = wpc_we_r;
   assign bus.init_done_o = init_done_r;

endmodule : jedro_1_wb_arbiter

// File: tb/tb_jedro_1_wb_arbiter.sv
// Directed self-checking bench for jedro_1_wb_arbiter.
module tb_jedro_1_wb_arbiter;

   logic clk;
   logic rstn;
   int   checks;
   int   errors;

   jedro_1_wb_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

   jedro_1_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
      chk({tag, "_we"},   32'(bus.wpc_we_o),   32'(we));
      chk({tag, "_addr"}, 32'(bus.wpc_addr_o), 32'(a));
      chk({tag, "_data"}, bus.wpc_data_o,      d);
   endtask

   task automatic chk_rdy(input string tag, input logic alu, input logic lsu);
      chk({tag, "_alu_rdy"}, 32'(bus.alu_ready_o), 32'(alu));
      chk({tag, "_lsu_rdy"}, 32'(bus.lsu_ready_o), 32'(lsu));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstn   = 1'b0;
      bus.alu_valid_i = 1'b1;
      bus.alu_addr_i  = 5'd9;
      bus.alu_data_i  = 32'h1111_1111;
      bus.lsu_valid_i = 1'b1;
      bus.lsu_addr_i  = 5'd10;
      bus.lsu_data_i  = 32'h2222_2222;

      // Reset state with both requesters valid
      #12;
      chk_port("rst", 1'b0, 5'd0, 32'h0);
      chk("rst_done", 32'(bus.init_done_o), 32'd0);
      chk_rdy("rst", 1'b0, 1'b0);

      // INIT sweep with both valids held high
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 1; i <= 31; i++) begin
         chk_rdy("init", 1'b0, 1'b0);
         step();
         chk_port("init", 1'b1, 5'(i), 32'h0);
         chk("init_done", 32'(bus.init_done_o), (i == 31) ? 32'd1 : 32'd0);
      end
      // First contended RUN cycle goes to LSU (pointer reset to ALU)
      chk_rdy("first_run", 1'b0, 1'b1);
      bus.alu_valid_i = 1'b0;
      bus.lsu_valid_i = 1'b0;
      #1;
      chk_rdy("idle", 1'b0, 1'b0);
      step();
      chk_port("idle_after_init", 1'b0, 5'd31, 32'h0);

      // Continuous contention: LSU, ALU, LSU, ...
      bus.alu_addr_i  = 5'd3;
      bus.alu_data_i  = 32'hA;
      bus.lsu_addr_i  = 5'd4;
      bus.lsu_data_i  = 32'hB;
      bus.alu_valid_i = 1'b1;
      bus.lsu_valid_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk_rdy("alt", (k % 2) == 1, (k % 2) == 0);
         step();
         if ((k % 2) == 0) chk_port("alt_lsu", 1'b1, 5'd4, 32'hB);
         else              chk_port("alt_alu", 1'b1, 5'd3, 32'hA);
      end
      bus.alu_valid_i = 1'b0;
      bus.lsu_valid_i = 1'b0;
      step();
      chk_port("alt_hold", 1'b0, 5'd3, 32'hA);

      // ALU-only single write
      bus.alu_addr_i  = 5'd5;
      bus.alu_data_i  = 32'hDEAD_BEEF;
      bus.alu_valid_i = 1'b1;
      #1;
      chk_rdy("alu_only", 1'b1, 1'b0);
      step();
      chk_port("alu_only", 1'b1, 5'd5, 32'hDEAD_BEEF);
      bus.alu_valid_i = 1'b0;
      step();
      chk_port("alu_only_hold", 1'b0, 5'd5, 32'hDEAD_BEEF);

      // LSU write to x0: accepted but not written
      bus.lsu_addr_i  = 5'd0;
      bus.lsu_data_i  = 32'h1234;
      bus.lsu_valid_i = 1'b1;
      #1;
      chk_rdy("lsu_x0", 1'b0, 1'b1);
      step();
      chk_port("lsu_x0", 1'b0, 5'd0, 32'h1234);
      bus.lsu_valid_i = 1'b0;
      step();
      chk_port("lsu_x0_hold", 1'b0, 5'd0, 32'h1234);

      // Last grant was LSU, so contention now goes to ALU
      bus.alu_addr_i  = 5'd7;
      bus.alu_data_i  = 32'h77;
      bus.lsu_addr_i  = 5'd8;
      bus.lsu_data_i  = 32'h88;
      bus.alu_valid_i = 1'b1;
      bus.lsu_valid_i = 1'b1;
      #1;
      chk_rdy("fair_a", 1'b1, 1'b0);
      step();
      chk_port("fair_a", 1'b1, 5'd7, 32'h77);
      bus.alu_valid_i = 1'b0;
      #1;
      chk_rdy("fair_l", 1'b0, 1'b1);
      step();
      chk_port("fair_l", 1'b1, 5'd8, 32'h88);
      bus.lsu_valid_i = 1'b0;

      // Reset mid-RUN, then reset again mid-INIT at address 12
      rstn = 1'b0;
      #1;
      chk_port("rst_run", 1'b0, 5'd0, 32'h0);
      chk("rst_run_done", 32'(bus.init_done_o), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         step();
         chk_port("init2", 1'b1, 5'(i), 32'h0);
      end
      #2;
      rstn = 1'b0;
      #1;
      chk_port("rst_mid_init", 1'b0, 5'd0, 32'h0);
      chk("rst_mid_init_done", 32'(bus.init_done_o), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 1; i <= 31; i++) begin
         step();
         chk_port("init3", 1'b1, 5'(i), 32'h0);
         chk("init3_done", 32'(bus.init_done_o), (i == 31) ? 32'd1 : 32'd0);
      end
      step();
      chk_port("init3_end", 1'b0, 5'd31, 32'h0);
      chk("init3_end_done", 32'(bus.init_done_o), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_jedro_1_wb_arbiter
